// File: rtl/nibble_slice_pkg.sv
// Shared defaults and state encoding for the nibble-slice arbiter slice of the codebase.
package nibble_slice_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int SLICE_W_DEF = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/nibble_slicer.sv
// Combinational slice select: top SLICE_W bits when hi=1, bottom SLICE_W bits otherwise.
module nibble_slicer #(
  parameter int DATA_W  = 8,
  parameter int SLICE_W = 4
) (
  input  logic [DATA_W-1:0]  data,
  input  logic               hi,
  output logic [SLICE_W-1:0] slice
);

  assign slice = hi ? data[DATA_W-1 -: SLICE_W] : data[SLICE_W-1:0];

endmodule

// File: rtl/nibble_slice_arbiter.sv
// Round-robin arbiter sharing one nibble slicer among NUM_REQ requesters, with a
// single registered result slot held under an output valid/ready handshake.
module nibble_slice_arbiter
  import nibble_slice_pkg::*;
#(
  parameter int  NUM_REQ = NUM_REQ_DEF,
  parameter int  DATA_W  = DATA_W_DEF,
  parameter int  SLICE_W = SLICE_W_DEF,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_hi,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [SLICE_W-1:0]        out_data,
  output logic [ID_W-1:0]           out_id,
  input  logic                      out_ready,
  output logic                      dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Requesters hold valid/data/hi until their ready bit is seen; out_data/out_id stay
  // stable while out_valid=1 and out_ready=0. req_ready never depends on req_data.

  state_e               state_q;
  state_e               state_d;
  logic [ID_W-1:0]      last_q;
  logic [ID_W-1:0]      winner;
  logic                 can_accept;
  logic                 accept;
  logic [DATA_W-1:0]    win_data;
  logic                 win_hi;
  logic [SLICE_W-1:0]   slice;

  // First set bit scanning ptr+1, ptr+2, ... modulo NUM_REQ, found by shifting a
  // doubled copy of the valid vector so the wrap needs no special case.
  function automatic logic [ID_W-1:0] rr_winner(
    input logic [NUM_REQ-1:0] valid,
    input logic [ID_W-1:0]    ptr
  );
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    int                   off;
    int                   sum;
    dbl = {valid, valid} >> (int'(ptr) + 1);
    rot = dbl[NUM_REQ-1:0];
    off = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = j;
    end
    sum = int'(ptr) + 1 + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  assign winner     = rr_winner(req_valid, last_q);
  assign can_accept = (state_q == EMPTY) | out_ready;
  // rst_n gating keeps req_ready low for the whole reset, not just after the first edge.
  assign accept     = rst_n & can_accept & (|req_valid);
  assign req_ready  = accept ? (NUM_REQ'(1) << winner) : '0;

  always_comb begin
    win_data = '0;
    win_hi   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        win_data = req_data[i*DATA_W +: DATA_W];
        win_hi   = req_hi[i];
      end
    end
  end

  nibble_slicer #(
    .DATA_W  (DATA_W),
    .SLICE_W (SLICE_W)
  ) u_slicer (
    .data  (win_data),
    .hi    (win_hi),
    .slice (slice)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_id   <= '0;
      last_q   <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      out_data <= slice;
      out_id   <= winner;
      last_q   <= winner;
    end
  end

  assign out_valid = (state_q == FULL);
  assign dbg_state = (state_q == FULL);

endmodule
